// File: rtl/timer_pkg.sv
// Shared types and constants for the timer_ctrl block and its prescaler.
// State encoding is fixed here so every consumer decodes the FSM identically.
package timer_pkg;

  localparam int CNT_W        = 8;
  localparam int DEF_NUM_COMP = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider: free-runs 0..i_div while enabled and flags o_tick on the terminal value.
// Held at zero whenever disabled so every run starts from a fresh prescale interval.
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [PRESC_W-1:0] i_div,
  output logic               o_tick
);

  logic [PRESC_W-1:0] r_cnt;
  logic               w_hit;

  assign w_hit  = (r_cnt == i_div);
  assign o_tick = i_en & w_hit;

  // A lowered i_div below r_cnt lets the count roll over modulo 2^PRESC_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Sequenced compare timer: IDLE/ARM/RUN/DONE FSM, 8-bit counter and shadowed compare bank.
// Compare values move from shadow to active only when arming or on a period wrap.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int NUM_COMP = DEF_NUM_COMP,
  parameter int PRESC_W  = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_start,
  input  logic                               i_stop,
  input  logic                               i_oneshot,
  input  logic [PRESC_W-1:0]                 i_presc_div,
  input  logic [CNT_W-1:0]                   i_period,
  input  logic [NUM_COMP-1:0]                i_match_wr_en,
  input  logic [CNT_W-1:0]                   i_match_wr_data,
  output logic [CNT_W-1:0]                   o_counter_value,
  output logic [NUM_COMP-1:0][CNT_W-1:0]     o_match_value,
  output logic                               o_running,
  output logic                               o_period_done,
  output logic                               o_done
);

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [CNT_W-1:0]                  r_cnt;
  logic [NUM_COMP-1:0][CNT_W-1:0]    r_shadow;
  logic [NUM_COMP-1:0][CNT_W-1:0]    r_match;
  logic                              r_period_done;

  logic w_tick;
  logic w_start;
  logic w_run;
  logic w_at_term;
  logic w_wrap;
  logic w_inc;
  logic w_clr;
  logic w_copy;

  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state == ST_RUN),
    .i_div  (i_presc_div),
    .o_tick (w_tick)
  );

  // Stop dominates: a simultaneous start is discarded and a pending wrap is dropped.
  assign w_start   = i_start & ~i_stop;
  assign w_run     = (r_state == ST_RUN) & ~i_stop;
  assign w_at_term = (r_cnt == i_period);
  assign w_wrap    = w_run & w_tick & w_at_term;
  assign w_inc     = w_run & w_tick & ~w_at_term;
  assign w_clr     = ((r_state == ST_IDLE) || (r_state == ST_DONE)) & w_start;
  assign w_copy    = ((r_state == ST_ARM) & ~i_stop) | w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_ARM;
      ST_ARM:  w_state_nxt = i_stop ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (i_stop)                    w_state_nxt = ST_IDLE;
        else if (w_wrap && i_oneshot)  w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (i_stop)       w_state_nxt = ST_IDLE;
        else if (w_start) w_state_nxt = ST_ARM;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_running = 1'b0;
    o_done    = 1'b0;
    case (r_state)
      ST_ARM,
      ST_RUN:  o_running = 1'b1;
      ST_DONE: o_done    = 1'b1;
      default: ;
    endcase
  end

  // Counter past a lowered period simply rolls through 255 back to 0 without a wrap event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_period_done <= 1'b0;
    end else begin
      r_period_done <= w_wrap;
      if (w_clr || w_wrap) begin
        r_cnt <= '0;
      end else if (w_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_match  <= '0;
    end else begin
      for (int k = 0; k < NUM_COMP; k++) begin
        if (i_match_wr_en[k]) r_shadow[k] <= i_match_wr_data;
      end
      if (w_copy) r_match <= r_shadow;
    end
  end

  assign o_counter_value = r_cnt;
  assign o_match_value   = r_match;
  assign o_period_done   = r_period_done;

endmodule

// File: tb/tb_timer_ctrl.sv
// Table-driven bench for timer_ctrl with a queue scoreboard, plus hand sequences
// for async reset, period 0 and a period lowered below the running count.
module tb_timer_ctrl;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0, stop = 1'b0, oneshot = 1'b0;
  logic [7:0]      presc = '0, period = '0;
  logic [2:0]      wr_en = '0;
  logic [7:0]      wr_data = '0;
  logic [7:0]      cnt;
  logic [2:0][7:0] match;
  logic            running, pd, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       start, stop, oneshot;
    logic [7:0] presc, period;
    logic [2:0] wr_en;
    logic [7:0] wr_data;
    logic [7:0] cnt;
    logic       run, pd, done;
    logic [7:0] m1;
  } vec_t;

  typedef struct {
    logic [7:0] cnt;
    logic       run, pd, done;
    logic [7:0] m1;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  timer_ctrl #(.NUM_COMP(3), .PRESC_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (start),
    .i_stop          (stop),
    .i_oneshot       (oneshot),
    .i_presc_div     (presc),
    .i_period        (period),
    .i_match_wr_en   (wr_en),
    .i_match_wr_data (wr_data),
    .o_counter_value (cnt),
    .o_match_value   (match),
    .o_running       (running),
    .o_period_done   (pd),
    .o_done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic sp, input logic os,
                     input logic [7:0] pr, input logic [7:0] pe,
                     input logic [2:0] we, input logic [7:0] wd,
                     input logic [7:0] c, input logic r, input logic p,
                     input logic d, input logic [7:0] m);
    vec_t v;
    v.start = s; v.stop = sp; v.oneshot = os; v.presc = pr; v.period = pe;
    v.wr_en = we; v.wr_data = wd; v.cnt = c; v.run = r; v.pd = p; v.done = d; v.m1 = m;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    start = v.start; stop = v.stop; oneshot = v.oneshot;
    presc = v.presc; period = v.period; wr_en = v.wr_en; wr_data = v.wr_data;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; wr_en = '0; wr_data = '0;
  endtask

  initial begin
    exp_t e;
    int   pd_seen;

    // Reset state while rst is held.
    #12;
    chk("rst cnt", cnt, 0);
    chk("rst running", running, 0);
    chk("rst pd", pd, 0);
    chk("rst done", done, 0);
    chk("rst match", match, 0);
    rst = 0;
    tick();

    //  st sp os pr pe  we      wd     cnt run pd dn m1
    // Continuous run, presc 0, period 3; shadow write mid-run and on a wrap edge.
    add(1, 0, 0, 0, 3, 3'b000, 8'h00, 0, 1, 0, 0, 8'h00);
    add(0, 0, 0, 0, 3, 3'b000, 8'h00, 0, 1, 0, 0, 8'h00);
    add(0, 0, 0, 0, 3, 3'b010, 8'h20, 1, 1, 0, 0, 8'h00);
    add(0, 0, 0, 0, 3, 3'b000, 8'h00, 2, 1, 0, 0, 8'h00);
    add(0, 0, 0, 0, 3, 3'b000, 8'h00, 3, 1, 0, 0, 8'h00);
    add(0, 0, 0, 0, 3, 3'b000, 8'h00, 0, 1, 1, 0, 8'h20);
    add(0, 0, 0, 0, 3, 3'b000, 8'h00, 1, 1, 0, 0, 8'h20);
    add(0, 0, 0, 0, 3, 3'b000, 8'h00, 2, 1, 0, 0, 8'h20);
    add(0, 0, 0, 0, 3, 3'b000, 8'h00, 3, 1, 0, 0, 8'h20);
    add(0, 0, 0, 0, 3, 3'b010, 8'h55, 0, 1, 1, 0, 8'h20);
    add(1, 0, 0, 0, 3, 3'b000, 8'h00, 1, 1, 0, 0, 8'h20);
    add(1, 1, 0, 0, 3, 3'b000, 8'h00, 1, 0, 0, 0, 8'h20);
    add(0, 1, 0, 0, 3, 3'b000, 8'h00, 1, 0, 0, 0, 8'h20);
    // Oneshot, presc 2, period 1; ARM picks up the 0x55 shadow.
    add(1, 0, 1, 2, 1, 3'b000, 8'h00, 0, 1, 0, 0, 8'h20);
    add(0, 0, 1, 2, 1, 3'b000, 8'h00, 0, 1, 0, 0, 8'h55);
    add(0, 0, 1, 2, 1, 3'b000, 8'h00, 0, 1, 0, 0, 8'h55);
    add(0, 0, 1, 2, 1, 3'b000, 8'h00, 0, 1, 0, 0, 8'h55);
    add(0, 0, 1, 2, 1, 3'b000, 8'h00, 1, 1, 0, 0, 8'h55);
    add(0, 0, 1, 2, 1, 3'b000, 8'h00, 1, 1, 0, 0, 8'h55);
    add(0, 0, 1, 2, 1, 3'b000, 8'h00, 1, 1, 0, 0, 8'h55);
    add(0, 0, 1, 2, 1, 3'b000, 8'h00, 0, 0, 1, 1, 8'h55);
    add(0, 0, 1, 2, 1, 3'b000, 8'h00, 0, 0, 0, 1, 8'h55);
    add(1, 0, 1, 2, 1, 3'b000, 8'h00, 0, 1, 0, 0, 8'h55);
    add(0, 1, 1, 2, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'h55);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      e.cnt = tbl[i].cnt; e.run = tbl[i].run; e.pd = tbl[i].pd;
      e.done = tbl[i].done; e.m1 = tbl[i].m1;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      chk($sformatf("vec%0d cnt", i), cnt, e.cnt);
      chk($sformatf("vec%0d running", i), running, e.run);
      chk($sformatf("vec%0d period_done", i), pd, e.pd);
      chk($sformatf("vec%0d done", i), done, e.done);
      chk($sformatf("vec%0d match1", i), match[1], e.m1);
    end
    idle_inputs();

    // Period 0: every tick wraps.
    presc = 0; period = 0; oneshot = 0; start = 1;
    tick();
    start = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("p0 pd%0d", k), pd, 1);
      chk($sformatf("p0 cnt%0d", k), cnt, 0);
    end
    stop = 1;
    tick();
    stop = 0;
    chk("p0 stop pd", pd, 0);
    chk("p0 stop running", running, 0);

    // Period lowered below the running count: rolls through 255 with no pulse.
    period = 10; start = 1;
    tick();
    start = 0;
    tick();
    repeat (7) tick();
    chk("low cnt7", cnt, 7);
    period = 2;
    pd_seen = 0;
    repeat (249) begin
      tick();
      if (pd) pd_seen++;
    end
    chk("low no pd", pd_seen, 0);
    chk("low wrap cnt", cnt, 0);
    tick();
    tick();
    chk("low cnt2", cnt, 2);
    tick();
    chk("low term pd", pd, 1);
    chk("low term cnt", cnt, 0);
    stop = 1;
    tick();
    stop = 0;

    // Asynchronous reset mid-run at count 5.
    period = 10; start = 1;
    tick();
    start = 0;
    tick();
    repeat (5) tick();
    chk("ar cnt5", cnt, 5);
    #3 rst = 1;
    #1;
    chk("ar cnt", cnt, 0);
    chk("ar running", running, 0);
    chk("ar pd", pd, 0);
    chk("ar done", done, 0);
    chk("ar match", match, 0);
    #2 rst = 0;
    tick();
    chk("ar post pd", pd, 0);
    chk("ar post running", running, 0);
    start = 1;
    tick();
    start = 0;
    chk("ar restart cnt", cnt, 0);
    chk("ar restart running", running, 1);
    tick();
    chk("ar restart match1", match[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter NUM_COMP, default 3, number of compare channels sequenced.
REQ-002 Parameter PRESC_W, default 8, prescaler divider width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle pulse; begins a count run.
REQ-006 stop  input  1  single-cycle pulse; aborts a run.
REQ-007 oneshot  input  1  1 = stop after one period, 0 = continuous.
REQ-008 presc_div  input  PRESC_W  tick every presc_div+1 clk cycles.
REQ-009 period  input  8  terminal count; counter spans 0..period.
REQ-010 match_wr_en  input  NUM_COMP  per-channel write strobe to shadow register.
REQ-011 match_wr_data  input  8  data for shadow write.
REQ-012 counter_value  output  8  current count, drives compare datapath.
REQ-013 match_value  output  NUM_COMP x 8  active compare values, drives compare datapath.
REQ-014 running  output  1  high in ARM and RUN states.
REQ-015 period_done  output  1  one-cycle pulse on each wrap/terminal count.
REQ-016 done  output  1  high in DONE state.

Function
REQ-017 FSM states IDLE, ARM, RUN, DONE; encoding in the shared package.
REQ-018 IDLE: start=1 -> ARM; counter_value cleared to 0 on that edge; prescaler cleared.
REQ-019 ARM: lasts exactly one cycle; all shadow registers copied to match_value; -> RUN.
REQ-020 RUN: prescaler counts 0..presc_div, generates internal tick when equal to presc_div, then reloads 0.
REQ-021 RUN, tick, counter_value < period: counter_value increments by 1.
REQ-022 RUN, tick, counter_value == period: counter_value -> 0, period_done=1 next cycle, shadows copied to match_value on same edge.
REQ-023 Wrap with oneshot=1: -> DONE, counter_value holds 0; oneshot=0: stays RUN.
REQ-024 period=0: every tick is a wrap; presc_div=0: tick every clk cycle.
REQ-025 DONE: start=1 -> ARM (restart as REQ-018); else hold.
REQ-026 stop=1 in ARM/RUN/DONE -> IDLE next edge, counter_value holds last value; stop beats start in same cycle.
REQ-027 start while in ARM or RUN: ignored.
REQ-028 Shadow writes accepted in every state; write and copy in same cycle: copy takes old shadow value, new value lands in shadow.
REQ-029 match_value changes only at ARM or wrap, never mid-period.
REQ-030 Inputs period, presc_div, oneshot sampled live; change mid-run takes effect at next comparison; period lowered below counter_value: counter continues to 255 and wraps to 0 (8-bit modulo), no period_done.

Reset
REQ-031 rst asserted: state IDLE, counter_value 0, prescaler 0, all shadow and match_value 0, running 0, period_done 0, done 0.
REQ-032 rst mid-run aborts immediately with no period_done pulse; first start after release behaves as REQ-018.

Structure
REQ-033 Package timer_pkg holds state enum, counter width constant (8), default NUM_COMP.
REQ-034 One sub-module timer_prescaler (counter + tick) instantiated once; FSM, counter, shadow bank in timer_ctrl.

Verification
REQ-035 presc_div=0, period=3, oneshot=0, start: counter 0,1,2,3,0,...; period_done every 4 cycles.
REQ-036 presc_div=2, period=1, oneshot=1: counter increments every 3 cycles, one period_done, done=1, counter 0.
REQ-037 match_wr_en[1] writes 0x20 mid-RUN: match_value[1] unchanged until wrap, equals 0x20 the cycle after wrap.
REQ-038 start and stop same cycle in RUN -> IDLE, running=0; start alone in RUN ignored.
REQ-039 rst asserted asynchronously at counter=5 -> all outputs 0 before next clk edge, no period_done.
REQ-040 period=0, presc_div=0: period_done high every cycle after ARM; period 10 -> 2 at counter 7: counts to 255, wraps, no pulse.
